hack_mem_map: RTL

// - Parametrised successor to the Hack data-memory map: RAM, screen and keyboard behind one 15-bit word address.
// - Adds registered reads with a valid strobe and a read-only keyboard fed by a valid/ready handshake.
// - Adds out-of-range address detection and an optional post-reset zeroing sweep.
// - Sits between the Hack CPU data port and the display/keyboard front-ends.

---
 rtl/hack_mem_pkg.sv | 31 +++
 rtl/hack_ram_bank.sv | 22 ++
 rtl/hack_mem_map.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types for the Hack data-memory map: region codes, controller states and the address decoder.
// Pure combinational helpers; no latency and no flow control.
package hack_mem_pkg;

   typedef enum logic [1:0] {
      RGN_RAM,
      RGN_SCREEN,
      RGN_KBD,
      RGN_NONE
   } region_t;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   // Unsigned compare; the keyboard sits one word past the end of the screen.
   function automatic region_t decode(input logic [31:0] addr,
                                      input int unsigned ram_words,
                                      input int unsigned screen_words);
      if (addr < ram_words)
         return RGN_RAM;
      else if (addr < ram_words + screen_words)
         return RGN_SCREEN;
      else if (addr == ram_words + screen_words)
         return RGN_KBD;
      else
         return RGN_NONE;
   endfunction

endpackage

// File: rtl/hack_ram_bank.sv
// Single-port synchronous RAM; the read registered on the same edge as a write returns the old word.
// One-cycle read latency; always ready, no backpressure.
module hack_ram_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16384
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         q
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= din;
      q <= mem[addr];
   end

endmodule

// File: rtl/hack_mem_map.sv
// Hack data-memory map (RAM, screen, read-only keyboard): reads valid one cycle after the address, kbd_ready high in RUN.
// Optional MEM_CLEAR_EN builds a post-reset sweep that zeroes both banks while busy is high.
module hack_mem_map
   import hack_mem_pkg::*;
#(
   parameter int          WIDTH        = 16,
   parameter int          ADDR_W       = 15,
   parameter int unsigned RAM_WORDS    = 16384,
   parameter int unsigned SCREEN_WORDS = 8192
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] address,
   input  logic              ld,
   output logic [WIDTH-1:0]  out,
   output logic              rd_valid,
   output logic              addr_err,
   output logic              busy,
   input  logic [WIDTH-1:0]  kbd_data,
   input  logic              kbd_valid,
   output logic              kbd_ready
);

   localparam int unsigned KBD_ADDR = RAM_WORDS + SCREEN_WORDS;
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int SCR_AW = $clog2(SCREEN_WORDS);

   state_t            state;
   logic              running;
   region_t           cpu_rgn;
   region_t           mem_rgn;
   region_t           rgn_q;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_din;
   logic              mem_we;
   logic [SCR_AW-1:0] scr_addr;
   logic [WIDTH-1:0]  ram_q;
   logic [WIDTH-1:0]  scr_q;
   logic [WIDTH-1:0]  kbd_reg;
   logic [WIDTH-1:0]  kbd_q;

   assign running   = (state == ST_RUN);
   assign kbd_ready = running && !rst;
   assign cpu_rgn   = decode(32'(address), RAM_WORDS, SCREEN_WORDS);

`ifdef MEM_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;

   // The sweep borrows the bank port; CPU writes are ignored until it ends.
   assign mem_addr = running ? address : clr_cnt;
   assign mem_din  = running ? in : '0;
   assign mem_we   = (running ? ld : 1'b1) && !rst;
`else
   assign mem_addr = address;
   assign mem_din  = in;
   assign mem_we   = ld && !rst;
   assign busy     = 1'b0;
`endif

   assign mem_rgn  = decode(32'(mem_addr), RAM_WORDS, SCREEN_WORDS);
   assign scr_addr = SCR_AW'(mem_addr - ADDR_W'(RAM_WORDS));

   hack_ram_bank #(.WIDTH(WIDTH), .DEPTH(RAM_WORDS)) u_ram (
      .clk  (clk),
      .we   (mem_we && (mem_rgn == RGN_RAM)),
      .addr (mem_addr[RAM_AW-1:0]),
      .din  (mem_din),
      .q    (ram_q)
   );

   hack_ram_bank #(.WIDTH(WIDTH), .DEPTH(SCREEN_WORDS)) u_screen (
      .clk  (clk),
      .we   (mem_we && (mem_rgn == RGN_SCREEN)),
      .addr (scr_addr),
      .din  (mem_din),
      .q    (scr_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         rgn_q    <= RGN_NONE;
         kbd_reg  <= '0;
         kbd_q    <= '0;
`ifdef MEM_CLEAR_EN
         state    <= ST_CLEAR;
         clr_cnt  <= '0;
         busy     <= 1'b1;
`else
         state    <= ST_RUN;
`endif
      end else begin
         rd_valid <= running;
         addr_err <= running && ((cpu_rgn == RGN_NONE) || ((cpu_rgn == RGN_KBD) && ld));
         rgn_q    <= running ? cpu_rgn : RGN_NONE;
         // Snapshot before capture so a same-cycle read sees the old scancode.
         kbd_q    <= kbd_reg;
         if (kbd_valid && kbd_ready)
            kbd_reg <= kbd_data;
`ifdef MEM_CLEAR_EN
         if (!running) begin
            if (clr_cnt == ADDR_W'(KBD_ADDR - 1)) begin
               state <= ST_RUN;
               busy  <= 1'b0;
            end else begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
            end
         end
`endif
      end
   end

   always_comb begin
      out = '0;
      if (rd_valid) begin
         case (rgn_q)
            RGN_RAM:    out = ram_q;
            RGN_SCREEN: out = scr_q;
            RGN_KBD:    out = kbd_q;
            default:    out = '0;
         endcase
      end
   end

endmodule
